// File: rtl/udma_i2c_pkg.sv
// udma_i2c_pkg: opcodes, engine commands and sequencer states shared by the I2C command sequencer
package udma_i2c_pkg;

  localparam logic [3:0] CMD_START   = 4'h0;
  localparam logic [3:0] CMD_STOP    = 4'h2;
  localparam logic [3:0] CMD_RD_ACK  = 4'h4;
  localparam logic [3:0] CMD_RD_NACK = 4'h6;
  localparam logic [3:0] CMD_WR      = 4'h8;
  localparam logic [3:0] CMD_WAIT    = 4'hA;
  localparam logic [3:0] CMD_RPT     = 4'hC;
  localparam logic [3:0] CMD_CFG     = 4'hE;

  typedef enum logic [1:0] {
    BUS_START = 2'd0,
    BUS_STOP  = 2'd1,
    BUS_WR    = 2'd2,
    BUS_RD    = 2'd3
  } bus_cmd_e;

  typedef enum logic [2:0] {
    FETCH,
    GET_OP1,
    GET_OP2,
    BUS_REQ,
    PUSH_RX,
    WAIT_CNT,
    DRAIN
  } seq_state_e;

endpackage

// File: rtl/udma_i2c_cmd_seq.sv
// udma_i2c_cmd_seq: decodes the uDMA TX command stream into byte-level I2C engine requests
module udma_i2c_cmd_seq
  import udma_i2c_pkg::*;
#(
  parameter int DIV_W = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             cfg_do_rst_i,
  input  logic [7:0]       data_tx_i,
  input  logic             data_tx_valid_i,
  output logic             data_tx_ready_o,
  output logic [7:0]       data_rx_o,
  output logic             data_rx_valid_o,
  input  logic             data_rx_ready_i,
  output logic             byte_req_o,
  output logic [1:0]       byte_cmd_o,
  output logic [7:0]       byte_din_o,
  output logic             byte_ack_o,
  input  logic             byte_done_i,
  input  logic [7:0]       byte_dout_i,
  input  logic             byte_al_i,
  output logic [DIV_W-1:0] clk_div_o,
  output logic             status_busy_o,
  output logic             status_al_o
);

  seq_state_e       state_q, state_d, rc_state;
  bus_cmd_e         cmd_q, cmd_d;
  logic [3:0]       op_q, op_d, opc;
  logic [7:0]       din_q, din_d, hi_q, hi_d, rx_q, rx_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] wait_q, wait_d, rpt_q, rpt_d, rc_rpt;
  logic             ack_q, ack_d, busy_q, busy_d, al_q, al_d, req_q, req_d;
  logic             fire, done, rpt_more;

  assign opc             = data_tx_i[7:4];
  assign data_tx_ready_o = rstn_i && (state_q inside {FETCH, GET_OP1, GET_OP2, DRAIN});
  assign fire            = data_tx_valid_i && data_tx_ready_o;
  assign done            = byte_done_i && req_q;
  assign rpt_more        = rpt_q > CNT_W'(1);
  // Repeat check: bus commands re-request, WR re-fetches its data byte, anything else runs once
  assign rc_state        = !rpt_more ? FETCH : op_q == CMD_WR ? GET_OP1 : !op_q[3] ? BUS_REQ : FETCH;
  assign rc_rpt          = (rpt_more && (op_q == CMD_WR || !op_q[3])) ? rpt_q - 1'b1 : '0;

  assign byte_req_o      = req_q;
  assign byte_cmd_o      = cmd_q;
  assign byte_din_o      = din_q;
  assign byte_ack_o      = ack_q;
  assign data_rx_o       = rx_q;
  assign data_rx_valid_o = state_q == PUSH_RX;
  assign clk_div_o       = div_q;
  assign status_busy_o   = busy_q;
  assign status_al_o     = al_q;

  // State and datapath registers
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= FETCH;
      cmd_q   <= BUS_START;
      op_q    <= '0;
      din_q   <= '0;
      hi_q    <= '0;
      rx_q    <= '0;
      div_q   <= '0;
      wait_q  <= '0;
      rpt_q   <= '0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
      al_q    <= 1'b0;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      op_q    <= op_d;
      din_q   <= din_d;
      hi_q    <= hi_d;
      rx_q    <= rx_d;
      div_q   <= div_d;
      wait_q  <= wait_d;
      rpt_q   <= rpt_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      al_q    <= al_d;
      req_q   <= req_d;
    end
  end

  // Next-state decode; soft reset overrides everything except the divider
  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    op_d    = op_q;
    din_d   = din_q;
    hi_d    = hi_q;
    rx_d    = rx_q;
    div_d   = div_q;
    wait_d  = wait_q;
    rpt_d   = rpt_q;
    ack_d   = ack_q;
    busy_d  = busy_q;
    al_d    = 1'b0;
    unique case (state_q)
      FETCH: begin
        if (fire && !data_tx_i[4]) begin
          op_d = opc;
          if (!opc[3]) begin
            cmd_d   = opc == CMD_START ? BUS_START : opc == CMD_STOP ? BUS_STOP : BUS_RD;
            ack_d   = opc == CMD_RD_NACK;
            state_d = BUS_REQ;
          end else begin
            cmd_d   = opc == CMD_WR ? BUS_WR : cmd_q;
            state_d = GET_OP1;
          end
        end
      end
      GET_OP1: begin
        if (fire) begin
          unique case (op_q)
            CMD_WR: begin
              din_d   = data_tx_i;
              state_d = BUS_REQ;
            end
            CMD_WAIT: begin
              wait_d  = CNT_W'(data_tx_i);
              state_d = data_tx_i == 8'd0 ? FETCH : WAIT_CNT;
              rpt_d   = data_tx_i == 8'd0 ? '0 : rpt_q;
            end
            CMD_RPT: begin
              rpt_d   = data_tx_i == 8'd0 ? CNT_W'(1) : CNT_W'(data_tx_i);
              state_d = FETCH;
            end
            CMD_CFG: begin
              hi_d    = data_tx_i;
              state_d = GET_OP2;
            end
            default: state_d = FETCH;
          endcase
        end
      end
      GET_OP2: begin
        if (fire) begin
          div_d   = DIV_W'({hi_q, data_tx_i});
          rpt_d   = '0;
          state_d = FETCH;
        end
      end
      BUS_REQ: begin
        if (done && byte_al_i) begin
          al_d    = 1'b1;
          busy_d  = 1'b0;
          rpt_d   = '0;
          state_d = DRAIN;
        end else if (done) begin
          busy_d  = cmd_q == BUS_START ? 1'b1 : cmd_q == BUS_STOP ? 1'b0 : busy_q;
          rx_d    = cmd_q == BUS_RD ? byte_dout_i : rx_q;
          state_d = cmd_q == BUS_RD ? PUSH_RX : rc_state;
          rpt_d   = cmd_q == BUS_RD ? rpt_q : rc_rpt;
        end
      end
      PUSH_RX: begin
        if (data_rx_ready_i) begin
          state_d = rc_state;
          rpt_d   = rc_rpt;
        end
      end
      WAIT_CNT: begin
        wait_d = wait_q - 1'b1;
        if (wait_q == CNT_W'(1)) begin
          state_d = FETCH;
          rpt_d   = '0;
        end
      end
      DRAIN:   state_d = DRAIN;
      default: state_d = FETCH;
    endcase
    if (cfg_do_rst_i) begin
      state_d = FETCH;
      busy_d  = 1'b0;
      al_d    = 1'b0;
      wait_d  = '0;
      rpt_d   = '0;
    end
  end

  // Request drops for at least one cycle after every completion
  always_comb req_d = state_d == BUS_REQ && !done;

endmodule

// File: tb/tb_udma_i2c_cmd_seq.sv
// tb_udma_i2c_cmd_seq: scoreboard bench with an engine responder and RX sink for the command sequencer
module tb_udma_i2c_cmd_seq;
  import udma_i2c_pkg::*;

  typedef struct {
    logic [1:0] cmd;
    logic [7:0] din;
    logic       ack;
    logic [7:0] dout;
    logic       al;
  } req_t;

  logic        clk_i = 1'b0;
  logic        rstn_i = 1'b0;
  logic        cfg_do_rst_i = 1'b0;
  logic [7:0]  data_tx_i = '0;
  logic        data_tx_valid_i = 1'b0;
  logic        data_tx_ready_o;
  logic [7:0]  data_rx_o;
  logic        data_rx_valid_o;
  logic        data_rx_ready_i;
  logic        byte_req_o;
  logic [1:0]  byte_cmd_o;
  logic [7:0]  byte_din_o;
  logic        byte_ack_o;
  logic        byte_done_i;
  logic [7:0]  byte_dout_i;
  logic        byte_al_i;
  logic [15:0] clk_div_o;
  logic        status_busy_o;
  logic        status_al_o;

  int   n_vec = 0;
  int   n_err = 0;
  int   eng_cnt = 0;
  logic exp_busy = 1'b0;
  logic rx_toggle = 1'b0;
  req_t exp_q[$];
  logic [7:0] rx_exp[$];

  udma_i2c_cmd_seq #(.DIV_W(16), .CNT_W(8)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .cfg_do_rst_i(cfg_do_rst_i),
    .data_tx_i(data_tx_i), .data_tx_valid_i(data_tx_valid_i), .data_tx_ready_o(data_tx_ready_o),
    .data_rx_o(data_rx_o), .data_rx_valid_o(data_rx_valid_o), .data_rx_ready_i(data_rx_ready_i),
    .byte_req_o(byte_req_o), .byte_cmd_o(byte_cmd_o), .byte_din_o(byte_din_o), .byte_ack_o(byte_ack_o),
    .byte_done_i(byte_done_i), .byte_dout_i(byte_dout_i), .byte_al_i(byte_al_i),
    .clk_div_o(clk_div_o), .status_busy_o(status_busy_o), .status_al_o(status_al_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_req(input logic [1:0] cmd, input logic [7:0] din, input logic ack,
                            input logic [7:0] dout, input logic al);
    exp_q.push_back('{cmd: cmd, din: din, ack: ack, dout: dout, al: al});
    if (cmd == BUS_RD && !al) rx_exp.push_back(dout);
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] b);
    logic ok;
    ok = 1'b0;
    data_tx_i = b;
    data_tx_valid_i = 1'b1;
    for (int i = 0; i < 300 && !ok; i++) begin
      ok = data_tx_ready_o;
      step(1);
    end
    data_tx_valid_i = 1'b0;
    chk("tx_accepted", 32'(ok), 1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 600; i++) begin
      if (exp_q.size() == 0 && rx_exp.size() == 0 && eng_cnt == 0 && data_tx_ready_o) break;
      step(1);
    end
    step(2);
    chk("req_queue_drained", 32'(exp_q.size()), 0);
    chk("rx_queue_drained", 32'(rx_exp.size()), 0);
  endtask

  // Engine responder: done 3 cycles after a request is seen, checks status right after
  initial begin
    req_t cur;
    bit post = 0;
    bit post2 = 0;
    byte_done_i = 1'b0;
    byte_dout_i = '0;
    byte_al_i = 1'b0;
    cur = '{cmd: 2'd0, din: 8'd0, ack: 1'b0, dout: 8'd0, al: 1'b0};
    forever begin
      @(posedge clk_i);
      #1;
      if (post2) begin
        chk("al_pulse_end", 32'(status_al_o), 0);
        post2 = 0;
      end
      if (post) begin
        chk("req_low_after_done", 32'(byte_req_o), 0);
        chk("busy_after_done", 32'(status_busy_o), 32'(exp_busy));
        chk("al_after_done", 32'(status_al_o), 32'(cur.al));
        post = 0;
        post2 = 1;
      end
      byte_done_i = 1'b0;
      byte_al_i = 1'b0;
      if (eng_cnt > 0) begin
        if (!byte_req_o) eng_cnt = 0;
        else begin
          eng_cnt--;
          if (eng_cnt == 0) begin
            byte_done_i = 1'b1;
            byte_dout_i = cur.dout;
            byte_al_i = cur.al;
            post = 1;
            if (cur.al) exp_busy = 1'b0;
            else if (cur.cmd == BUS_START) exp_busy = 1'b1;
            else if (cur.cmd == BUS_STOP) exp_busy = 1'b0;
          end
        end
      end else if (byte_req_o) begin
        chk("req_expected", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          cur = exp_q.pop_front();
          chk("req_cmd", 32'(byte_cmd_o), 32'(cur.cmd));
          if (cur.cmd == BUS_WR) chk("req_din", 32'(byte_din_o), 32'(cur.din));
          if (cur.cmd == BUS_RD) chk("req_ack", 32'(byte_ack_o), 32'(cur.ack));
        end else cur = '{cmd: byte_cmd_o, din: 8'd0, ack: 1'b0, dout: 8'd0, al: 1'b0};
        eng_cnt = 3;
      end
    end
  end

  // RX sink: optional ready toggling every 2 cycles, compares each accepted byte in order
  initial begin
    int ph = 0;
    logic [7:0] e;
    data_rx_ready_i = 1'b1;
    forever begin
      @(negedge clk_i);
      if (rx_toggle) begin
        ph++;
        if (ph == 2) begin
          data_rx_ready_i = !data_rx_ready_i;
          ph = 0;
        end
      end else data_rx_ready_i = 1'b1;
      if (data_rx_valid_o && data_rx_ready_i) begin
        chk("rx_expected", 32'(rx_exp.size() > 0), 1);
        if (rx_exp.size() > 0) begin
          e = rx_exp.pop_front();
          chk("rx_data", 32'(data_rx_o), 32'(e));
        end
      end
    end
  end

  initial begin
    int n;
    step(3);
    chk("rst_tx_ready", 32'(data_tx_ready_o), 0);
    chk("rst_rx_valid", 32'(data_rx_valid_o), 0);
    chk("rst_rx_data", 32'(data_rx_o), 0);
    chk("rst_req", 32'(byte_req_o), 0);
    chk("rst_cmd", 32'(byte_cmd_o), 0);
    chk("rst_din", 32'(byte_din_o), 0);
    chk("rst_ack", 32'(byte_ack_o), 0);
    chk("rst_clk_div", 32'(clk_div_o), 0);
    chk("rst_busy", 32'(status_busy_o), 0);
    chk("rst_al", 32'(status_al_o), 0);
    rstn_i = 1'b1;
    step(2);
    chk("fetch_ready", 32'(data_tx_ready_o), 1);

    // START, WR 0xA0, STOP
    expect_req(BUS_START, 8'h00, 1'b0, 8'h00, 1'b0);
    expect_req(BUS_WR, 8'hA0, 1'b0, 8'h00, 1'b0);
    expect_req(BUS_STOP, 8'h00, 1'b0, 8'h00, 1'b0);
    send(8'h00);
    send(8'h80);
    send(8'hA0);
    send(8'h20);
    wait_idle();

    // CFG divider 0x012C, no engine request
    send(8'hE0);
    send(8'h01);
    chk("clk_div_before_low", 32'(clk_div_o), 0);
    send(8'h2C);
    chk("clk_div_loaded", 32'(clk_div_o), 32'h012C);
    wait_idle();

    // RPT 3 x RD_ACK under RX back-pressure
    rx_toggle = 1'b1;
    expect_req(BUS_RD, 8'h00, 1'b0, 8'h11, 1'b0);
    expect_req(BUS_RD, 8'h00, 1'b0, 8'h22, 1'b0);
    expect_req(BUS_RD, 8'h00, 1'b0, 8'h33, 1'b0);
    send(8'hC0);
    send(8'h03);
    send(8'h40);
    wait_idle();
    rx_toggle = 1'b0;

    // RPT 2 x WR with fresh data bytes
    expect_req(BUS_WR, 8'h5A, 1'b0, 8'h00, 1'b0);
    expect_req(BUS_WR, 8'hA5, 1'b0, 8'h00, 1'b0);
    send(8'hC0);
    send(8'h02);
    send(8'h80);
    send(8'h5A);
    send(8'hA5);
    wait_idle();

    // Single RD_NACK
    expect_req(BUS_RD, 8'h00, 1'b1, 8'h9C, 1'b0);
    send(8'h60);
    wait_idle();

    // Arbitration lost on WR, drain, soft reset, restart
    expect_req(BUS_START, 8'h00, 1'b0, 8'h00, 1'b0);
    expect_req(BUS_WR, 8'h77, 1'b0, 8'h00, 1'b1);
    send(8'h00);
    send(8'h80);
    send(8'h77);
    wait_idle();
    chk("busy_after_al", 32'(status_busy_o), 0);
    send(8'h20);
    send(8'h00);
    step(6);
    chk("drain_ready", 32'(data_tx_ready_o), 1);
    cfg_do_rst_i = 1'b1;
    step(1);
    cfg_do_rst_i = 1'b0;
    chk("srst_clk_div_kept", 32'(clk_div_o), 32'h012C);
    expect_req(BUS_START, 8'h00, 1'b0, 8'h00, 1'b0);
    send(8'h00);
    wait_idle();
    chk("busy_after_restart", 32'(status_busy_o), 1);

    // WAIT 5 gives exactly 5 stalled cycles
    send(8'hA0);
    send(8'h05);
    n = 0;
    while (!data_tx_ready_o && n < 50) begin
      n++;
      step(1);
    end
    chk("wait_cycles", 32'(n), 5);

    // WAIT 0 leaves immediately
    send(8'hA0);
    send(8'h00);
    chk("wait_zero_ready", 32'(data_tx_ready_o), 1);

    // Soft reset in the 2nd wait cycle
    send(8'hA0);
    send(8'h05);
    step(1);
    chk("wait_stalled", 32'(data_tx_ready_o), 0);
    cfg_do_rst_i = 1'b1;
    exp_busy = 1'b0;
    step(1);
    cfg_do_rst_i = 1'b0;
    chk("srst_wait_ready", 32'(data_tx_ready_o), 1);
    chk("srst_busy", 32'(status_busy_o), 0);

    // Async reset during a STOP request with the bus owned
    expect_req(BUS_START, 8'h00, 1'b0, 8'h00, 1'b0);
    send(8'h00);
    wait_idle();
    expect_req(BUS_STOP, 8'h00, 1'b0, 8'h00, 1'b0);
    send(8'h20);
    step(1);
    chk("pre_arst_req", 32'(byte_req_o), 1);
    rstn_i = 1'b0;
    exp_busy = 1'b0;
    #1;
    chk("arst_req", 32'(byte_req_o), 0);
    chk("arst_busy", 32'(status_busy_o), 0);
    chk("arst_clk_div", 32'(clk_div_o), 0);
    chk("arst_tx_ready", 32'(data_tx_ready_o), 0);
    step(2);
    rstn_i = 1'b1;
    step(6);
    chk("post_arst_ready", 32'(data_tx_ready_o), 1);
    chk("post_arst_req", 32'(byte_req_o), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
